// File: rtl/store_v.sv
// Vector store engine: pulls packed tiles from the buffer file and writes them element by element to DRAM.
// Optional STORE_ZERO_PAD_EN pads the final partial tile with zero writes up to the tile boundary.
module store_v #(
    parameter int DATA_WIDTH = 8,
    parameter int TILE_WIDTH = 256,
    parameter int ADDR_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [ADDR_WIDTH-1:0] dram_addr,
    input  logic [9:0]            length,
    output logic                  tile_req,
    input  logic [TILE_WIDTH-1:0] tile_in,
    input  logic                  tile_in_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  valid_out
);
    localparam int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH;
    localparam int TP_W       = $clog2(TILE_ELEMS);

    typedef enum logic [2:0] {IDLE, REQ_TILE, WAIT_TILE, WRITE, FINISH} state_t;

    state_t                                state;
    logic [ADDR_WIDTH-1:0]                 base;
    logic [9:0]                            len;
    logic [10:0]                           elem_cnt;
    logic [TP_W-1:0]                       tile_pos;
    logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] tile_q;

    logic [10:0]           elem_nxt;
    logic [TP_W-1:0]       pos_nxt;
    logic                  last_elem;
    logic                  last_in_tile;
    logic [DATA_WIDTH-1:0] nxt_data;

    always_comb begin
        elem_nxt     = elem_cnt + 11'd1;
        pos_nxt      = tile_pos + TP_W'(1);
        last_in_tile = (tile_pos == TP_W'(TILE_ELEMS - 1));
`ifdef STORE_ZERO_PAD_EN
        // Past len we keep writing zeros until the tile boundary closes the op.
        last_elem = (elem_nxt >= {1'b0, len}) && last_in_tile;
        nxt_data  = (elem_nxt < {1'b0, len}) ? tile_q[pos_nxt] : '0;
`else
        last_elem = (elem_nxt == {1'b0, len});
        nxt_data  = tile_q[pos_nxt];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            len       <= '0;
            elem_cnt  <= '0;
            tile_pos  <= '0;
            tile_q    <= '0;
            tile_req  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            tile_req  <= 1'b0;
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        base     <= dram_addr;
                        len      <= length;
                        elem_cnt <= '0;
                        tile_pos <= '0;
                        busy     <= 1'b1;
                        if (length == 10'd0) begin
                            state <= FINISH;
                        end else begin
                            state    <= REQ_TILE;
                            tile_req <= 1'b1;
                        end
                    end
                end
                REQ_TILE: state <= WAIT_TILE;
                WAIT_TILE: begin
                    if (tile_in_valid) begin
                        tile_q    <= tile_in;
                        tile_pos  <= '0;
                        state     <= WRITE;
                        mem_we    <= 1'b1;
                        mem_addr  <= base + ADDR_WIDTH'(elem_cnt);
                        mem_wdata <= tile_in[DATA_WIDTH-1:0];
                    end
                end
                WRITE: begin
                    // Address/data only advance on acceptance, so a stall holds them.
                    if (mem_ready) begin
                        elem_cnt <= elem_nxt;
                        tile_pos <= pos_nxt;
                        if (last_elem) begin
                            mem_we <= 1'b0;
                            state  <= FINISH;
                        end else if (last_in_tile) begin
                            mem_we   <= 1'b0;
                            state    <= REQ_TILE;
                            tile_req <= 1'b1;
                        end else begin
                            mem_addr  <= base + ADDR_WIDTH'(elem_nxt);
                            mem_wdata <= nxt_data;
                        end
                    end
                end
                FINISH: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    valid_out <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_store_v.sv
// Self-checking bench for store_v: randomized tiles/handshake against a write-list reference model.
module tb_store_v;
`ifdef STORE_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, valid_in, tile_in_valid, mem_ready;
    logic         tile_req, mem_we, busy, valid_out;
    logic [23:0]  dram_addr, mem_addr;
    logic [9:0]   length;
    logic [255:0] tile_in;
    logic [7:0]   mem_wdata;

    store_v dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .dram_addr(dram_addr), .length(length),
        .tile_req(tile_req), .tile_in(tile_in), .tile_in_valid(tile_in_valid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .busy(busy), .valid_out(valid_out)
    );

    initial forever #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    int treq_cnt, vo_cnt, vo_cyc, t0, tile_idx, rdy_mode = 0, st_cnt = 0;
    int exp_nt, exp_nw;
    bit stalled = 1'b0;
    logic [23:0]  s_addr;
    logic [7:0]   s_data;
    logic [255:0] tile_mem [0:31];
    logic [23:0]  obs_addr[$], exp_addr[$];
    logic [7:0]   obs_data[$], exp_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory side: drives mem_ready and records accepted writes, all at negedge.
    initial begin
        mem_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy_mode == 0) mem_ready = 1'b1;
            else if (rdy_mode == 1) begin
                if (mem_we === 1'b1) begin
                    if (st_cnt == 3) begin mem_ready = 1'b1; st_cnt = 0; end
                    else begin mem_ready = 1'b0; st_cnt++; end
                end else begin
                    mem_ready = 1'b0; st_cnt = 0;
                end
            end else mem_ready = 1'($urandom_range(0, 1));
            if (rst) stalled = 1'b0;
            else begin
                if (stalled) begin
                    checks++;
                    if (!(mem_we === 1'b1 && mem_addr === s_addr && mem_wdata === s_data)) begin
                        failures++;
                        $display("FAIL stall_hold: we=%b addr=%h data=%h required we=1 addr=%h data=%h",
                                 mem_we, mem_addr, mem_wdata, s_addr, s_data);
                    end
                end
                stalled = (mem_we === 1'b1) && !mem_ready;
                s_addr  = mem_addr;
                s_data  = mem_wdata;
                if (mem_we === 1'b1 && mem_ready) begin
                    obs_addr.push_back(mem_addr);
                    obs_data.push_back(mem_wdata);
                end
                if (tile_req === 1'b1) treq_cnt++;
                if (valid_out === 1'b1) begin
                    vo_cnt++;
                    vo_cyc = cyc;
                    checks++;
                    if (busy !== 1'b0) begin
                        failures++;
                        $display("FAIL busy_at_done: busy=%b required 0", busy);
                    end
                end
            end
        end
    end

    // Buffer file: answers each tile_req with the next stored tile one cycle later.
    initial begin
        tile_in_valid = 1'b0;
        tile_in = '0;
        forever begin
            @(negedge clk);
            if (tile_req === 1'b1 && !rst) begin
                @(posedge clk); #1;
                tile_in = tile_mem[tile_idx % 32];
                tile_idx++;
                tile_in_valid = 1'b1;
                @(posedge clk); #1;
                tile_in_valid = 1'b0;
                tile_in = {8{$urandom()}};
            end
        end
    end

    task automatic fill_tiles();
        for (int k = 0; k < 32; k++)
            for (int w = 0; w < 8; w++) tile_mem[k][w*32 +: 32] = $urandom();
    endtask

    // Reference: the op is a flat list of (base+i mod 2^24, element i of the tile stream).
    function automatic void build_model(input logic [23:0] b, input int n);
        exp_addr.delete(); exp_data.delete();
        exp_nt = (n + 31) / 32;
        exp_nw = PAD ? exp_nt * 32 : n;
        for (int i = 0; i < exp_nw; i++) begin
            exp_addr.push_back(24'(b + i));
            exp_data.push_back(i < n ? tile_mem[i / 32][(i % 32) * 8 +: 8] : 8'h00);
        end
    endfunction

    function automatic int write_errs();
        int e = 0;
        if (obs_addr.size() != exp_addr.size()) e++;
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) e++;
        return e;
    endfunction

    task automatic start_op(input logic [23:0] b, input int n, input int mode);
        rdy_mode = mode;
        obs_addr.delete(); obs_data.delete();
        treq_cnt = 0; vo_cnt = 0; tile_idx = 0; vo_cyc = 0;
        build_model(b, n);
        @(negedge clk); #2;
        dram_addr = b; length = 10'(n); valid_in = 1'b1; t0 = cyc;
        @(negedge clk); #2;
        valid_in = 1'b0; dram_addr = 24'($urandom()); length = 10'($urandom());
    endtask

    task automatic run_op(input logic [23:0] b, input int n, input int mode, input bit dup, output bit ok);
        start_op(b, n, mode);
        ok = 1'b0;
        for (int c = 0; c < 5000 && !ok; c++) begin
            valid_in = dup && (c == 4);
            if (dup && c == 4) begin dram_addr = b ^ 24'h5A5A5A; length = 10'(n + 7); end
            @(negedge clk); #2;
            if (vo_cnt > 0) ok = 1'b1;
        end
        valid_in = 1'b0;
        repeat (6) @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b0; dram_addr = '0; length = '0;
        #1;
        checks++;
        if ({tile_req, mem_we, busy, valid_out} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctl: req/we/busy/vo=%b required 0000", {tile_req, mem_we, busy, valid_out});
        end
        checks++;
        if (mem_addr !== 24'h0 || mem_wdata !== 8'h0) begin
            failures++;
            $display("FAIL reset_data: addr=%h data=%h required 0", mem_addr, mem_wdata);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_tile();
        bit ok;
        for (int j = 0; j < 32; j++) tile_mem[0][j*8 +: 8] = 8'(j);
        run_op(24'h000100, 32, 0, 1'b0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_done: no valid_out required one"); end
        checks++; if (write_errs() != 0) begin failures++; $display("FAIL single_writes: n=%0d errs=%0d required n=32 errs=0", obs_addr.size(), write_errs()); end
        checks++; if (treq_cnt != 1) begin failures++; $display("FAIL single_treq: %0d required 1", treq_cnt); end
        checks++; if (vo_cyc - t0 != 36) begin failures++; $display("FAIL single_latency: %0d required 36", vo_cyc - t0); end
    endtask

    task automatic test_two_tiles();
        bit ok;
        fill_tiles();
        run_op(24'h000200, 40, 0, 1'b0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL two_done: no valid_out required one"); end
        checks++; if (write_errs() != 0) begin failures++; $display("FAIL two_writes: n=%0d errs=%0d required n=%0d errs=0", obs_addr.size(), write_errs(), exp_nw); end
        checks++; if (treq_cnt != 2) begin failures++; $display("FAIL two_treq: %0d required 2", treq_cnt); end
        checks++; if (vo_cyc - t0 != 2 + 2 * exp_nt + exp_nw) begin failures++; $display("FAIL two_latency: %0d required %0d", vo_cyc - t0, 2 + 2 * exp_nt + exp_nw); end
    endtask

    task automatic test_zero_len();
        bit ok;
        run_op(24'h000300, 0, 0, 1'b0, ok);
        checks++; if (!ok || vo_cnt != 1) begin failures++; $display("FAIL zero_done: vo=%0d required 1", vo_cnt); end
        checks++; if (obs_addr.size() != 0 || treq_cnt != 0) begin failures++; $display("FAIL zero_activity: writes=%0d treq=%0d required 0 0", obs_addr.size(), treq_cnt); end
        checks++; if (vo_cyc - t0 != 2) begin failures++; $display("FAIL zero_latency: %0d required 2", vo_cyc - t0); end
    endtask

    task automatic test_stall();
        bit ok;
        fill_tiles();
        run_op(24'h000400, 5, 1, 1'b0, ok);
        checks++; if (!ok || vo_cnt != 1) begin failures++; $display("FAIL stall_done: vo=%0d required 1", vo_cnt); end
        checks++; if (write_errs() != 0) begin failures++; $display("FAIL stall_writes: n=%0d errs=%0d required n=%0d errs=0", obs_addr.size(), write_errs(), exp_nw); end
        rdy_mode = 0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        fill_tiles();
        run_op(24'h000500, 20, 0, 1'b1, ok);
        checks++; if (!ok || vo_cnt != 1) begin failures++; $display("FAIL busy_ignore_vo: vo=%0d required 1", vo_cnt); end
        checks++; if (write_errs() != 0) begin failures++; $display("FAIL busy_ignore_writes: n=%0d errs=%0d required n=%0d errs=0", obs_addr.size(), write_errs(), exp_nw); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n0, c;
        fill_tiles();
        start_op(24'h000600, 32, 0);
        c = 0;
        while (obs_addr.size() < 10 && c < 200) begin @(negedge clk); #2; c++; end
        checks++; if (c >= 200) begin failures++; $display("FAIL rst_mid_progress: writes=%0d required 10", obs_addr.size()); end
        rst = 1'b1;
        #1;
        checks++;
        if ({tile_req, mem_we, busy, valid_out} !== 4'b0 || mem_addr !== 24'h0 || mem_wdata !== 8'h0) begin
            failures++;
            $display("FAIL rst_mid_outputs: ctl=%b addr=%h data=%h required 0", {tile_req, mem_we, busy, valid_out}, mem_addr, mem_wdata);
        end
        n0 = obs_addr.size();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        #2;
        checks++; if (obs_addr.size() != n0 || vo_cnt != 0) begin failures++; $display("FAIL rst_mid_abort: writes=%0d vo=%0d required %0d 0", obs_addr.size(), vo_cnt, n0); end
        fill_tiles();
        run_op(24'h000700, 4, 0, 1'b0, ok);
        checks++; if (!ok || vo_cnt != 1 || write_errs() != 0) begin failures++; $display("FAIL rst_mid_recover: vo=%0d errs=%0d required 1 0", vo_cnt, write_errs()); end
        checks++; if (vo_cyc - t0 != 2 + 2 * exp_nt + exp_nw) begin failures++; $display("FAIL rst_mid_latency: %0d required %0d", vo_cyc - t0, 2 + 2 * exp_nt + exp_nw); end
    endtask

    task automatic test_random();
        bit ok;
        logic [23:0] b;
        int n;
        for (int t = 0; t < 8; t++) begin
            fill_tiles();
            b = (t == 0) ? 24'hFFFFF0 : 24'($urandom());
            n = (t == 1) ? 64 : int'($urandom_range(1, 100));
            run_op(b, n, 2, 1'b0, ok);
            checks++; if (!ok || vo_cnt != 1) begin failures++; $display("FAIL rand%0d_vo: vo=%0d required 1", t, vo_cnt); end
            checks++; if (write_errs() != 0) begin failures++; $display("FAIL rand%0d_writes: base=%h len=%0d n=%0d errs=%0d required n=%0d errs=0", t, b, n, obs_addr.size(), write_errs(), exp_nw); end
            checks++; if (treq_cnt != exp_nt) begin failures++; $display("FAIL rand%0d_treq: %0d required %0d", t, treq_cnt, exp_nt); end
        end
        rdy_mode = 0;
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_two_tiles();
        test_zero_len();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/store_v.md
Name: store_v

Overview:
- Vector store engine, write-side counterpart of the vector loader; executes the STORE opcode (5'h03) for the execution unit.
- Pulls packed tiles from the vector buffer file one at a time, serializes them into DATA_WIDTH elements, and writes them to DRAM at consecutive byte addresses.
- Uses a ready/enable handshake on the DRAM port, so a slow memory can stall it.

Parameters:
- DATA_WIDTH, 8, element width in bits; one element occupies one DRAM address.
- TILE_WIDTH, 256, packed tile width in bits; TILE_ELEMS = TILE_WIDTH/DATA_WIDTH (32 by default).
- ADDR_WIDTH, 24, DRAM byte address width.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid_in  input  1  one-cycle start pulse; sampled only in IDLE.
- dram_addr  input  ADDR_WIDTH  base DRAM address; latched at start.
- length  input  10  element count, 0..1023; latched at start.
- tile_req  output  1  one-cycle pulse requesting the next tile from the buffer file.
- tile_in  input  TILE_WIDTH  packed tile; element i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- tile_in_valid  input  1  tile_in is valid this cycle.
- mem_we  output  1  DRAM write request.
- mem_addr  output  ADDR_WIDTH  DRAM write address.
- mem_wdata  output  DATA_WIDTH  DRAM write data.
- mem_ready  input  1  DRAM accepts the write; a write completes on a cycle with mem_we && mem_ready.
- busy  output  1  high in every state except IDLE.
- valid_out  output  1  one-cycle completion pulse.

Behaviour:
- Reset values: tile_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, valid_out=0. State returns to IDLE and all counters clear.
- Reset mid-operation aborts immediately. No further writes occur and valid_out is not produced.
- FSM states: IDLE, REQ_TILE, WAIT_TILE, WRITE, FINISH.
- IDLE:
  - On valid_in, latch base=dram_addr and len=length, and clear elem_cnt and tile_pos.
  - If len==0, go to FINISH; otherwise go to REQ_TILE.
  - valid_in in any other state is ignored.
- REQ_TILE: assert tile_req for exactly one cycle, then go to WAIT_TILE.
- WAIT_TILE:
  - Hold until tile_in_valid. No timeout.
  - Then capture tile_in into an internal tile register, set tile_pos=0, and go to WRITE.
  - tile_in_valid in any other state is ignored.
- WRITE:
  - Drive mem_we=1, mem_addr=base+elem_cnt, and mem_wdata=tile register element [tile_pos].
  - mem_addr arithmetic is modulo 2^ADDR_WIDTH (wraps silently).
  - Address and data are registered and stay stable while mem_ready=0.
  - On each accepted write, increment elem_cnt and tile_pos.
  - After the accepted write where elem_cnt+1==len, deassert mem_we next cycle and go to FINISH.
  - Otherwise, after the accepted write where tile_pos+1==TILE_ELEMS, deassert mem_we and go to REQ_TILE.
  - A final partial tile writes only the remaining len mod TILE_ELEMS elements; the unused tile elements are dropped.
- FINISH: pulse valid_out for one cycle, then go to IDLE. busy drops in the same cycle valid_out is high.
- Throughput and latency:
  - With mem_ready tied high, each tile costs 2 overhead cycles plus 1 cycle per element, assuming tile_in_valid arrives the cycle after tile_req.
  - Total latency for length=32: 1 (IDLE) + 1 (REQ_TILE) + 1 (WAIT_TILE) + 32 (WRITE) + 1 (FINISH).
- Tile count per operation is ceil(len/TILE_ELEMS); tile_req pulses exactly that many times.

Optional Feature:
- Macro: STORE_ZERO_PAD_EN.
- Defined: the final partial tile is padded with zero writes up to the TILE_ELEMS boundary. Total writes = ceil(len/TILE_ELEMS)*TILE_ELEMS, and the address continues incrementing through the padding. len==0 still performs no writes.
- Undefined: exactly len writes, as in Behaviour.

Test Plan:
- length=32, dram_addr=0x000100, tile bytes 0x00..0x1F, mem_ready=1 -> one tile_req; 32 writes to 0x100..0x11F with data 0x00..0x1F; valid_out 36 cycles after valid_in.
- length=40, dram_addr=0x000200 -> two tile_req pulses; 40 writes to 0x200..0x227; second tile writes only its elements 0..7. With STORE_ZERO_PAD_EN: 64 writes, and 0x228..0x23F receive 0x00.
- length=0 -> no tile_req, no mem_we; valid_out exactly 2 cycles after valid_in.
- length=5, mem_ready low for 3 cycles on every write -> mem_addr and mem_wdata held stable while stalled; exactly 5 writes, each address written once; valid_out after all 5.
- A second valid_in while busy, with different dram_addr and length -> ignored; only the first operation's writes appear; exactly one valid_out.
- rst asserted after 10 of 32 writes -> all outputs 0 in the same cycle; no valid_out; a new valid_in with length=4 afterwards completes normally with 4 writes.
